// File: rtl/rm_violation_reporter_if.sv
// Report stream carrying the violation record at the head of the reporter FIFO
// to the CSR/trace consumer.
interface rm_violation_reporter_if #(
  parameter int LANE_W   = 3,
  parameter int RULE_W   = 4,
  parameter int TS_WIDTH = 16
);
  logic                report_valid_o;
  logic                report_ready_i;
  logic [LANE_W-1:0]   report_lane_o;
  logic [RULE_W-1:0]   report_rule_o;
  logic [TS_WIDTH-1:0] report_ts_o;

  modport master (output report_valid_o, report_lane_o, report_rule_o, report_ts_o,
                  input  report_ready_i);
  modport slave  (input  report_valid_o, report_lane_o, report_rule_o, report_ts_o,
                  output report_ready_i);
endinterface

// File: rtl/rm_violation_reporter.sv
// Turns rm_monitor violation-flag rising edges into timestamped records, arbitrated
// round-robin into a show-ahead FIFO, with a sticky irq and a lost-violation counter.
module rm_violation_reporter #(
  parameter int NUM_LANES  = 7,
  parameter int NUM_RULES  = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_WIDTH   = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_LANES-1:0][NUM_RULES-1:0] monitor_i,
  input  logic [NUM_LANES-1:0]                lane_reset_i,
  rm_violation_reporter_if.master             rpt,
  output logic                                irq_o,
  input  logic                                irq_clear_i,
  output logic [7:0]                          overflow_cnt_o,
  output logic                                pending_o
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int RULE_W = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
  localparam int NIDX   = NUM_LANES * NUM_RULES;
  localparam int IDX_W  = (NIDX > 1) ? $clog2(NIDX) : 1;
  localparam int CNT_W  = $clog2(NIDX + 1);
  localparam int SUM_W  = CNT_W + 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CW     = PTR_W + 1;

  typedef struct packed {
    logic [LANE_W-1:0]   lane;
    logic [RULE_W-1:0]   rule;
    logic [TS_WIDTH-1:0] ts;
  } rec_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [LANE_W-1:0] lane;
    logic [RULE_W-1:0] rule;
  } sel_t;

  logic [NUM_LANES-1:0][NUM_RULES-1:0] w_pend, w_lost;
  logic [IDX_W-1:0]    r_rr;
  logic [TS_WIDTH-1:0] r_ts;
  rec_t                r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr, r_rd;
  logic [CW-1:0]       r_cnt;
  logic                r_irq;
  logic [7:0]          r_ovf;

  logic                w_full, w_gnt, w_push, w_pop;
  logic                w_hi_any, w_lo_any;
  sel_t                w_hi, w_lo, w_sel;
  logic [CNT_W-1:0]    w_lost_cnt;
  logic [SUM_W-1:0]    w_ovf_sum;

  // Per-lane edge detect and pending bookkeeping.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [NUM_RULES-1:0] r_prev, r_pend, w_hit, w_rise;

    always_comb begin
      w_hit = '0;
      for (int r = 0; r < NUM_RULES; r++)
        w_hit[r] = w_gnt && (w_sel.lane == LANE_W'(g)) && (w_sel.rule == RULE_W'(r));
    end

    assign w_rise    = monitor_i[g] & ~r_prev;
    // A rise landing on the grant cycle re-arms the bit instead of being lost.
    assign w_lost[g] = {NUM_RULES{~lane_reset_i[g]}} & ~w_hit & w_rise & r_pend;
    assign w_pend[g] = r_pend;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_prev <= '0;
        r_pend <= '0;
      end else if (lane_reset_i[g]) begin
        r_prev <= '0;
        r_pend <= '0;
      end else begin
        r_prev <= monitor_i[g];
        r_pend <= (r_pend & ~w_hit) | w_rise;
      end
    end
  end

  // Round-robin: lowest pending idx at/above r_rr, else lowest pending overall.
  always_comb begin
    w_hi_any = 1'b0;
    w_lo_any = 1'b0;
    w_hi     = '0;
    w_lo     = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      for (int r = NUM_RULES - 1; r >= 0; r--) begin
        if (w_pend[l][r]) begin
          w_lo_any = 1'b1;
          w_lo     = '{idx: IDX_W'(l * NUM_RULES + r), lane: LANE_W'(l), rule: RULE_W'(r)};
          if (IDX_W'(l * NUM_RULES + r) >= r_rr) begin
            w_hi_any = 1'b1;
            w_hi     = '{idx: IDX_W'(l * NUM_RULES + r), lane: LANE_W'(l), rule: RULE_W'(r)};
          end
        end
      end
    end
  end

  assign w_sel  = w_hi_any ? w_hi : w_lo;
  assign w_full = (r_cnt == CW'(FIFO_DEPTH));
  assign w_gnt  = !w_full && w_lo_any;
  assign w_push = w_gnt;
  assign w_pop  = rpt.report_valid_o && rpt.report_ready_i;

  always_comb begin
    w_lost_cnt = '0;
    for (int l = 0; l < NUM_LANES; l++)
      for (int r = 0; r < NUM_RULES; r++)
        w_lost_cnt = w_lost_cnt + CNT_W'(w_lost[l][r]);
  end

  assign w_ovf_sum = {{CNT_W{1'b0}}, r_ovf} + SUM_W'(w_lost_cnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr  <= '0;
      r_ts  <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_irq <= 1'b0;
      r_ovf <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
      if (w_gnt)
        r_rr <= (w_sel.idx == IDX_W'(NIDX - 1)) ? '0 : w_sel.idx + IDX_W'(1);
      if (w_push) begin
        r_mem[r_wr] <= '{lane: w_sel.lane, rule: w_sel.rule, ts: r_ts};
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      if (w_push != w_pop) r_cnt <= w_push ? r_cnt + CW'(1) : r_cnt - CW'(1);
      if (w_push)           r_irq <= 1'b1;
      else if (irq_clear_i) r_irq <= 1'b0;
      r_ovf <= (w_ovf_sum > SUM_W'(255)) ? 8'hFF : w_ovf_sum[7:0];
    end
  end

  assign rpt.report_valid_o = (r_cnt != '0);
  assign rpt.report_lane_o  = r_mem[r_rd].lane;
  assign rpt.report_rule_o  = r_mem[r_rd].rule;
  assign rpt.report_ts_o    = r_mem[r_rd].ts;
  assign irq_o              = r_irq;
  assign overflow_cnt_o     = r_ovf;
  assign pending_o          = |w_pend;
endmodule

// File: tb/tb_rm_violation_reporter.sv
// Bench for rm_violation_reporter: directed vector table, corner-case sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_rm_violation_reporter;
  localparam int NL = 7, NR = 10, N = NL * NR, DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NL-1:0][NR-1:0] mon;
  logic [NL-1:0]         lrst;
  logic                  irq_clr, irq, pend_o;
  logic [7:0]            ovf;

  rm_violation_reporter_if #(.LANE_W(3), .RULE_W(4), .TS_WIDTH(16)) rpt();

  rm_violation_reporter #(.NUM_LANES(NL), .NUM_RULES(NR), .FIFO_DEPTH(DEPTH), .TS_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .monitor_i(mon), .lane_reset_i(lrst), .rpt(rpt),
    .irq_o(irq), .irq_clear_i(irq_clr), .overflow_cnt_o(ovf), .pending_o(pend_o));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Reference model: pending/prev per flat index, a queue as the FIFO.
  typedef struct { int l; int r; int ts; } mrec_t;
  bit    m_pend [N];
  bit    m_prev [N];
  mrec_t m_q [$];
  int    m_rr, m_ts, m_ovf;
  bit    m_irq;
  int    d_seen [$];

  task automatic chk(string name, logic [31:0] act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int seen_at(int k);
    return (k < d_seen.size()) ? d_seen[k] : -1;
  endfunction

  task automatic model_reset();
    foreach (m_pend[i]) begin m_pend[i] = 0; m_prev[i] = 0; end
    m_q.delete();
    m_rr = 0; m_ts = 0; m_ovf = 0; m_irq = 0;
  endtask

  task automatic model_step();
    bit gnt = 0;
    int gidx = 0;
    int lost = 0;
    bit rise;
    if (m_q.size() < DEPTH)
      for (int k = 0; k < N; k++)
        if (!gnt && m_pend[(m_rr + k) % N]) begin gnt = 1; gidx = (m_rr + k) % N; end
    if (m_q.size() != 0 && rpt.report_ready_i) m_q.pop_front();
    for (int i = 0; i < N; i++) begin
      rise = mon[i / NR][i % NR] && !m_prev[i];
      if (lrst[i / NR]) begin
        m_pend[i] = 0; m_prev[i] = 0;
      end else begin
        m_prev[i] = mon[i / NR][i % NR];
        if (gnt && gidx == i)       m_pend[i] = rise;
        else if (rise && m_pend[i]) lost++;
        else if (rise)              m_pend[i] = 1;
      end
    end
    if (gnt) begin
      m_q.push_back('{gidx / NR, gidx % NR, m_ts});
      m_rr  = (gidx + 1) % N;
      m_irq = 1;
    end else if (irq_clr) m_irq = 0;
    m_ovf = (m_ovf + lost > 255) ? 255 : m_ovf + lost;
    m_ts  = (m_ts + 1) % 65536;
  endtask

  task automatic check_model();
    bit any = 0;
    foreach (m_pend[i]) any |= m_pend[i];
    chk("valid", rpt.report_valid_o, int'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("lane", rpt.report_lane_o, m_q[0].l);
      chk("rule", rpt.report_rule_o, m_q[0].r);
      chk("ts",   rpt.report_ts_o,   m_q[0].ts);
    end
    chk("irq",     irq,    int'(m_irq));
    chk("ovf",     ovf,    m_ovf);
    chk("pending", pend_o, int'(any));
  endtask

  // Inputs are set before calling; outputs are compared 1 time unit after the edge.
  task automatic tick();
    if (rpt.report_valid_o && rpt.report_ready_i)
      d_seen.push_back(int'(rpt.report_lane_o) * NR + int'(rpt.report_rule_o));
    model_step();
    @(posedge clk); #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mon = '0; lrst = '0; irq_clr = 1'b0; rpt.report_ready_i = 1'b0;
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic flip(int b);
    mon[b / NR][b % NR] = ~mon[b / NR][b % NR];
  endtask

  typedef struct {
    bit mon_on; bit rdy; bit clr;
    bit e_valid; int e_lane; int e_rule; int e_ts; bit e_pend; bit e_irq;
  } vec_t;
  vec_t tbl [9];

  initial begin
    // Single violation on [2][5]; edge n after reset leaves the timestamp at n.
    tbl[0] = '{0, 1, 0,  0, 0, 0, 0,  0, 0};
    tbl[1] = '{0, 1, 0,  0, 0, 0, 0,  0, 0};
    tbl[2] = '{1, 1, 0,  0, 0, 0, 0,  1, 0};
    tbl[3] = '{1, 1, 0,  1, 2, 5, 3,  0, 1};
    tbl[4] = '{1, 1, 0,  0, 0, 0, 0,  0, 1};
    tbl[5] = '{1, 1, 0,  0, 0, 0, 0,  0, 1};
    tbl[6] = '{1, 1, 1,  0, 0, 0, 0,  0, 0};
    tbl[7] = '{0, 1, 0,  0, 0, 0, 0,  0, 0};
    tbl[8] = '{0, 0, 0,  0, 0, 0, 0,  0, 0};

    do_reset();
    chk("rst.valid", rpt.report_valid_o, 0);
    chk("rst.irq", irq, 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.pending", pend_o, 0);

    foreach (tbl[i]) begin
      mon = '0; mon[2][5] = tbl[i].mon_on;
      rpt.report_ready_i = tbl[i].rdy; irq_clr = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d.valid", i),   rpt.report_valid_o, int'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.pending", i), pend_o,             int'(tbl[i].e_pend));
      chk($sformatf("tbl%0d.irq", i),     irq,                int'(tbl[i].e_irq));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d.lane", i), rpt.report_lane_o, tbl[i].e_lane);
        chk($sformatf("tbl%0d.rule", i), rpt.report_rule_o, tbl[i].e_rule);
        chk($sformatf("tbl%0d.ts", i),   rpt.report_ts_o,   tbl[i].e_ts);
      end
    end
    irq_clr = 1'b0;

    // Round-robin order from rr=0, then with rr just past (0,0).
    do_reset();
    rpt.report_ready_i = 1'b1;
    d_seen.delete();
    mon[0][0] = 1; mon[3][1] = 1; mon[6][9] = 1;
    repeat (6) tick();
    chk("rr.count", d_seen.size(), 3);
    chk("rr.first", seen_at(0), 0);
    chk("rr.second", seen_at(1), 31);
    chk("rr.third", seen_at(2), 69);
    mon = '0; tick();
    mon[0][0] = 1; repeat (4) tick();
    mon = '0; tick();
    d_seen.delete();
    mon[0][0] = 1; mon[3][1] = 1;
    repeat (6) tick();
    chk("rr2.first", seen_at(0), 31);
    chk("rr2.second", seen_at(1), 0);

    // Backpressure: six rises, FIFO holds four, two wait pending.
    mon = '0; tick(); tick();
    rpt.report_ready_i = 1'b0;
    d_seen.delete();
    mon[1][0] = 1; mon[1][3] = 1; mon[2][7] = 1; mon[4][4] = 1; mon[5][0] = 1; mon[6][1] = 1;
    repeat (8) tick();
    chk("bp.valid", rpt.report_valid_o, 1);
    chk("bp.pending", pend_o, 1);
    rpt.report_ready_i = 1'b1;
    repeat (12) tick();
    chk("bp.count", d_seen.size(), 6);
    chk("bp.r0", seen_at(0), 10);
    chk("bp.r1", seen_at(1), 13);
    chk("bp.r2", seen_at(2), 27);
    chk("bp.r3", seen_at(3), 44);
    chk("bp.r4", seen_at(4), 50);
    chk("bp.r5", seen_at(5), 61);
    chk("bp.ovf", ovf, 0);

    // Lane reset: lane-4 records in FIFO survive, pending [4][2] clears then re-arms.
    mon = '0; tick();
    rpt.report_ready_i = 1'b0;
    mon[4][0] = 1; mon[4][1] = 1; mon[4][3] = 1; mon[4][5] = 1;
    repeat (6) tick();
    mon = '0; tick();
    mon[4][2] = 1; tick(); tick();
    chk("lr.pend_before", pend_o, 1);
    lrst[4] = 1'b1; tick(); lrst = '0;
    chk("lr.pend_cleared", pend_o, 0);
    chk("lr.ovf", ovf, 0);
    tick();
    chk("lr.rearmed", pend_o, 1);
    d_seen.delete();
    rpt.report_ready_i = 1'b1;
    repeat (10) tick();
    chk("lr.count", d_seen.size(), 5);
    chk("lr.r0", seen_at(0), 40);
    chk("lr.r3", seen_at(3), 45);
    chk("lr.last", seen_at(4), 42);

    // Overflow with a full FIFO and [1][1] pending, then saturation.
    mon = '0; tick();
    rpt.report_ready_i = 1'b0;
    mon[6][2] = 1; mon[6][3] = 1; mon[6][4] = 1; mon[6][5] = 1; mon[1][1] = 1;
    repeat (6) tick();
    mon[1][1] = 0; tick(); mon[1][1] = 1; tick();
    chk("ovf.one", ovf, 1);
    mon[1][1] = 0; tick(); mon[1][1] = 1; tick();
    chk("ovf.two", ovf, 2);
    repeat (300) begin mon[1][1] = 0; tick(); mon[1][1] = 1; tick(); end
    chk("ovf.sat", ovf, 255);
    chk("ovf.valid", rpt.report_valid_o, 1);
    rpt.report_ready_i = 1'b1; mon = '0;
    repeat (10) tick();

    // Asynchronous reset with a full FIFO and irq set.
    rpt.report_ready_i = 1'b0;
    mon[5][1] = 1; mon[5][2] = 1; mon[5][3] = 1; mon[5][4] = 1;
    repeat (6) tick();
    chk("ar.pre_valid", rpt.report_valid_o, 1);
    chk("ar.pre_irq", irq, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar.valid", rpt.report_valid_o, 0);
    chk("ar.lane", rpt.report_lane_o, 0);
    chk("ar.rule", rpt.report_rule_o, 0);
    chk("ar.ts", rpt.report_ts_o, 0);
    chk("ar.irq", irq, 0);
    chk("ar.ovf", ovf, 0);
    chk("ar.pending", pend_o, 0);
    mon = '0;
    model_reset();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();

    // Randomized traffic; second half starves the consumer to exercise full/overflow.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) flip(int'($urandom_range(0, N - 1)));
      if ($urandom_range(0, 5) == 0) flip(int'($urandom_range(0, N - 1)));
      lrst = '0;
      if ($urandom_range(0, 39) == 0) lrst[$urandom_range(0, NL - 1)] = 1'b1;
      rpt.report_ready_i = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      irq_clr = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
